// File: rtl/alu_seq.sv
// Pipelined, handshaked ALU with status flags and an optional shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier (sel=111); otherwise sel=111 flags err.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  // state | meaning
  // IDLE  | accept requests; single-cycle ops load results directly
  // MUL   | one shift-add step per cycle until the counter reaches zero
  // DONE  | load the finished product into the result registers
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  state_t state;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_y;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;
  logic             accept;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    res_y     = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (sel)
      3'b000: begin
        res_y     = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        res_y     = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
        res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: res_y = a & b;
      3'b011: res_y = a | b;
      3'b100: res_y = a ^ b;
      3'b101: res_y = (b >= SH_LIM) ? '0 : (a << b);
      3'b110: res_y = (b >= SH_LIM) ? '0 : (a >> b);
      default: begin
`ifndef ALU_MUL_EN
        res_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     add_hi;

  // Multiplier sits in the low half of prod and is consumed LSB-first.
  assign add_hi = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_MUL_EN
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (sel == 3'b111) begin
              state <= MUL;
              prod  <= {{WIDTH{1'b0}}, b};
              mcand <= a;
              cnt   <= CW'(WIDTH);
            end else begin
`else
            begin
`endif
              out_valid <= 1'b1;
              y         <= res_y;
              y_hi      <= '0;
              carry     <= res_carry;
              ovf       <= res_ovf;
              zero      <= (res_y == '0);
              neg       <= res_y[WIDTH-1];
              err       <= res_err;
            end
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (cnt != '0) begin
            prod <= {add_hi, prod[WIDTH-1:1]};
            cnt  <= cnt - 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // Acceptance guaranteed a free or draining output, so no stall here.
          out_valid <= 1'b1;
          y         <= prod[WIDTH-1:0];
          y_hi      <= prod[2*WIDTH-1:WIDTH];
          carry     <= |prod[2*WIDTH-1:WIDTH];
          ovf       <= 1'b0;
          zero      <= (prod[WIDTH-1:0] == '0);
          neg       <= prod[WIDTH-1];
          err       <= 1'b0;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): directed scenarios plus random traffic
// against a transaction/latency-level reference model.
module tb_alu_seq;
  localparam int W = 4;
  localparam bit MUL_EN =
`ifdef ALU_MUL_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         carry, ovf, zero, neg, err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y; int y_hi; bit carry; bit ovf; bit zero; bit neg; bit err;
  } res_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   exp_valid;
  int   mul_left;
  res_t cur;
  res_t pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int to_s(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic res_t ref_calc(input int ua, input int ub, input int op);
    res_t r;
    int   s;
    r = '{default: 0};
    case (op)
      0: begin
        r.y = (ua + ub) % 16; r.carry = (ua + ub) >= 16;
        s = to_s(ua) + to_s(ub); r.ovf = (s > 7) || (s < -8);
      end
      1: begin
        r.y = (ua - ub + 16) % 16; r.carry = ua < ub;
        s = to_s(ua) - to_s(ub); r.ovf = (s > 7) || (s < -8);
      end
      2: r.y = ua & ub;
      3: r.y = ua | ub;
      4: r.y = ua ^ ub;
      5: r.y = (ub >= W) ? 0 : (ua * (1 << ub)) % 16;
      6: r.y = (ub >= W) ? 0 : ua / (1 << ub);
      default: begin
        if (MUL_EN) begin
          r.y = (ua * ub) % 16; r.y_hi = (ua * ub) / 16; r.carry = r.y_hi != 0;
        end else begin
          r.err = 1'b1;
        end
      end
    endcase
    r.zero = (r.y == 0);
    r.neg  = (r.y >= 8);
    return r;
  endfunction

  task automatic compare_model();
    bit exp_ready;
    exp_ready = (mul_left == 0) && (!exp_valid || out_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, exp_ready);
    if (exp_valid) begin
      chk("y", y, cur.y);
      chk("y_hi", y_hi, cur.y_hi);
      chk("carry", carry, cur.carry);
      chk("ovf", ovf, cur.ovf);
      chk("zero", zero, cur.zero);
      chk("neg", neg, cur.neg);
      chk("err", err, cur.err);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic drive(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                       input logic [2:0] sv, input logic ordy);
    bit   acc;
    res_t r;
    in_valid = iv; a = av; b = bv; sel = sv; out_ready = ordy;
    acc = iv && (mul_left == 0) && (!exp_valid || ordy);
    if (exp_valid && ordy) exp_valid = 1'b0;
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin exp_valid = 1'b1; cur = pend; end
    end else if (acc) begin
      r = ref_calc(int'(av), int'(bv), int'(sv));
      if (sv == 3'b111 && MUL_EN) begin pend = r; mul_left = W + 2; end
      else begin cur = r; exp_valid = 1'b1; end
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_valid = 1'b0; mul_left = 0;
    repeat (cycles) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 4'h0);
    chk("rst_y_hi", y_hi, 4'h0);
    chk("rst_flags", {carry, ovf, zero, neg, err}, 5'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b0;
    do_reset(2);

    drive(1, 4'd5, 4'd3, 3'b000, 1);
    chk("add_y", y, 4'h8);
    chk("add_flags", {carry, ovf, neg, zero}, 4'b0110);

    drive(1, 4'd3, 4'd5, 3'b001, 1);
    chk("sub_y", y, 4'hE);
    chk("sub_flags", {carry, ovf, neg}, 3'b101);
    drive(1, 4'hF, 4'hF, 3'b001, 1);
    chk("sub_zero", {y, zero}, 5'b0000_1);

    drive(0, 0, 0, 0, 1);
    drive(1, 4'd5, 4'd3, 3'b100, 0);
    chk("bp_xor_y", y, 4'h6);
    chk("bp_in_ready", in_ready, 1'b0);
    drive(1, 4'd5, 4'd3, 3'b011, 0);
    chk("bp_hold_y", y, 4'h6);
    drive(1, 4'd5, 4'd3, 3'b011, 1);
    chk("bp_or_y", y, 4'h7);
    chk("bp_valid", out_valid, 1'b1);

    drive(1, 4'd3, 4'd2, 3'b101, 1);
    chk("shl_y", y, 4'hC);
    drive(1, 4'd8, 4'd5, 3'b110, 1);
    chk("shr_big", {y, zero}, 5'b0000_1);
    drive(1, 4'd8, 4'd3, 3'b110, 1);
    chk("shr_y", y, 4'h1);

    drive(1, 4'd7, 4'd6, 3'b111, 1);
    if (MUL_EN) begin
      for (int i = 0; i < 5; i++) begin
        chk("mul_busy_ready", in_ready, 1'b0);
        drive(0, 0, 0, 0, 1);
      end
      chk("mul_busy_ready", in_ready, 1'b0);
      drive(0, 0, 0, 0, 1);
      chk("mul_valid", out_valid, 1'b1);
      chk("mul_y", {y_hi, y}, 8'h2A);
      chk("mul_carry", carry, 1'b1);
    end else begin
      chk("nomul_res", {out_valid, err, zero, y, y_hi}, 11'b111_0000_0000);
    end

    drive(0, 0, 0, 0, 1);
    drive(1, 4'd7, 4'd6, 3'b111, 1);
    drive(0, 0, 0, 0, 1);
    do_reset(1);
    drive(0, 0, 0, 0, 1);
    chk("abort_no_result", out_valid, 1'b0);
    drive(1, 4'd1, 4'd1, 3'b000, 1);
    chk("post_rst_add", y, 4'h2);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom), 3'($urandom),
            $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
